// File: rtl/mmio_peripheral.sv
// -----------------------------------------------------------------------------
// mmio_peripheral
//
// Memory-mapped peripheral block that sits beside the data memory in the MEM
// stage. It decodes a 32-byte window at BASE_ADDR and exposes the following
// registers:
//   0x00 TH      timer reload value            (R/W)
//   0x04 TL      timer count                   (R/W)
//   0x08 TCON    {irq_status, irq_en, enable}  (R/W, upper bits read 0)
//   0x0C LEDS    8-bit LED register            (R/W, upper bits read 0)
//   0x10 DIGITS  16-bit display register       (R/W, upper bits read 0)
//   0x14 SYSTICK free-running cycle counter    (RO, writes ignored)
//   0x18/0x1C    reserved                      (read 0, writes ignored)
// The DIGITS register is time-multiplexed onto a 4-digit common-anode
// 7-segment display. Each digit is driven for SCAN_DIV clock cycles.
//
// Ports:
//   clk          system clock, all state updates on its rising edge
//   reset        synchronous, active-high reset
//   i_addr       byte address from EX/MEM (ALU result)
//   i_WriteData  store data
//   i_MemRead    load strobe
//   i_MemWrite   store strobe
//   o_sel        high when i_addr falls inside the peripheral window
//   o_ReadData   combinational load data (0 unless a load hits the window)
//   o_irq        timer interrupt request (TCON[2])
//   o_leds       LED register
//   o_an         digit anodes, active-low one-hot
//   o_bcd7       segments {dp,g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module mmio_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          SCAN_DIV  = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_WriteData,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  output logic        o_sel,
  output logic [31:0] o_ReadData,
  output logic        o_irq,
  output logic [7:0]  o_leds,
  output logic [3:0]  o_an,
  output logic [7:0]  o_bcd7
);

  // ---------------------------------------------------------------------------
  // Register offsets (word index inside the window, i_addr[4:2])
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    OFF_TH      = 3'd0,
    OFF_TL      = 3'd1,
    OFF_TCON    = 3'd2,
    OFF_LEDS    = 3'd3,
    OFF_DIGITS  = 3'd4,
    OFF_SYSTICK = 3'd5,
    OFF_RSVD6   = 3'd6,
    OFF_RSVD7   = 3'd7
  } reg_off_e;

  // TCON bit positions
  localparam int TCON_EN     = 0;
  localparam int TCON_IRQ_EN = 1;
  localparam int TCON_IRQ    = 2;

  // Scan counter sized to hold 0 .. SCAN_DIV-1
  localparam int                SCAN_W    = $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]       th;
  logic [31:0]       tl;
  logic [2:0]        tcon;
  logic [7:0]        leds;
  logic [15:0]       digits;
  logic [31:0]       systick;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit_idx;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  reg_off_e off;
  logic     wr_en;
  logic     we_th;
  logic     we_tl;
  logic     we_tcon;
  logic     we_leds;
  logic     we_digits;

  assign o_sel = (i_addr[31:5] == BASE_ADDR[31:5]);
  assign off   = reg_off_e'(i_addr[4:2]);
  assign wr_en = i_MemWrite && o_sel;

  // SYSTICK and the reserved slots have no write enable: stores there are
  // simply dropped.
  assign we_th     = wr_en && (off == OFF_TH);
  assign we_tl     = wr_en && (off == OFF_TL);
  assign we_tcon   = wr_en && (off == OFF_TCON);
  assign we_leds   = wr_en && (off == OFF_LEDS);
  assign we_digits = wr_en && (off == OFF_DIGITS);

  // ---------------------------------------------------------------------------
  // Timer
  // ---------------------------------------------------------------------------
  logic tl_at_max;
  logic timer_en;
  logic irq_set;

  assign tl_at_max = (tl == 32'hFFFF_FFFF);
  assign timer_en  = tcon[TCON_EN];
  // Status is raised on the reload cycle only when interrupts are enabled.
  assign irq_set   = timer_en && tcon[TCON_IRQ_EN] && tl_at_max;

  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values of its neighbours, independent of
  // statement order inside the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      th <= 32'h0;
    end else if (we_th) begin
      th <= i_WriteData;
    end
  end

  // A software store to TL takes priority over the increment/reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      tl <= 32'h0;
    end else if (we_tl) begin
      tl <= i_WriteData;
    end else if (timer_en) begin
      if (tl_at_max) begin
        tl <= th;
      end else begin
        tl <= tl + 32'd1;
      end
    end
  end

  // A software store to TCON overrides a simultaneous status set, which lets
  // software clear the flag on the exact overflow cycle. Writing bit 2 high
  // raises a software interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcon <= 3'b000;
    end else if (we_tcon) begin
      tcon <= i_WriteData[2:0];
    end else if (irq_set) begin
      tcon[TCON_IRQ] <= 1'b1;
    end
  end

  assign o_irq = tcon[TCON_IRQ];

  // ---------------------------------------------------------------------------
  // LED and display data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      leds <= 8'h00;
    end else if (we_leds) begin
      leds <= i_WriteData[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digits <= 16'h0000;
    end else if (we_digits) begin
      digits <= i_WriteData[15:0];
    end
  end

  assign o_leds = leds;

  // ---------------------------------------------------------------------------
  // SYSTICK: free-running, wraps at 2^32, independent of the timer enable
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      systick <= 32'h0;
    end else begin
      systick <= systick + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan: each digit is held for SCAN_DIV cycles. DIGITS writes do
  // not disturb the scan position.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  logic [3:0] nibble;

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    nibble = digits[3:0];
    unique case (digit_idx)
      2'd0: nibble = digits[3:0];
      2'd1: nibble = digits[7:4];
      2'd2: nibble = digits[11:8];
      2'd3: nibble = digits[15:12];
    endcase
  end

  assign o_an = ~(4'b0001 << digit_idx);

  // Hex to active-low segments {dp,g,f,e,d,c,b,a}; dp is always off (1).
  always_comb begin
    o_bcd7 = 8'hFF;
    unique case (nibble)
      4'h0: o_bcd7 = 8'hC0;
      4'h1: o_bcd7 = 8'hF9;
      4'h2: o_bcd7 = 8'hA4;
      4'h3: o_bcd7 = 8'hB0;
      4'h4: o_bcd7 = 8'h99;
      4'h5: o_bcd7 = 8'h92;
      4'h6: o_bcd7 = 8'h82;
      4'h7: o_bcd7 = 8'hF8;
      4'h8: o_bcd7 = 8'h80;
      4'h9: o_bcd7 = 8'h90;
      4'hA: o_bcd7 = 8'h88;
      4'hB: o_bcd7 = 8'h83;
      4'hC: o_bcd7 = 8'hC6;
      4'hD: o_bcd7 = 8'hA1;
      4'hE: o_bcd7 = 8'h86;
      4'hF: o_bcd7 = 8'h8E;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read path: zero-latency so the MEM stage can forward the value to ID
  // in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_ReadData = 32'h0;
    if (i_MemRead && o_sel) begin
      unique case (off)
        OFF_TH:      o_ReadData = th;
        OFF_TL:      o_ReadData = tl;
        OFF_TCON:    o_ReadData = {29'd0, tcon};
        OFF_LEDS:    o_ReadData = {24'd0, leds};
        OFF_DIGITS:  o_ReadData = {16'd0, digits};
        OFF_SYSTICK: o_ReadData = systick;
        OFF_RSVD6:   o_ReadData = 32'h0;
        OFF_RSVD7:   o_ReadData = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_peripheral.sv
// -----------------------------------------------------------------------------
// tb_mmio_peripheral
//
// Directed testbench for mmio_peripheral with SCAN_DIV = 4. Inputs are driven
// 1 ns after each rising edge; combinational outputs are sampled before the
// next rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mmio_peripheral;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] i_addr;
  logic [31:0] i_WriteData;
  logic        i_MemRead;
  logic        i_MemWrite;
  logic        o_sel;
  logic [31:0] o_ReadData;
  logic        o_irq;
  logic [7:0]  o_leds;
  logic [3:0]  o_an;
  logic [7:0]  o_bcd7;

  int errors = 0;
  int checks = 0;

  mmio_peripheral #(
    .BASE_ADDR (B),
    .SCAN_DIV  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_addr      (i_addr),
    .i_WriteData (i_WriteData),
    .i_MemRead   (i_MemRead),
    .i_MemWrite  (i_MemWrite),
    .o_sel       (o_sel),
    .o_ReadData  (o_ReadData),
    .o_irq       (o_irq),
    .o_leds      (o_leds),
    .o_an        (o_an),
    .o_bcd7      (o_bcd7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bus helpers (stimulus only)
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    i_addr      = a;
    i_WriteData = d;
    i_MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    i_MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    i_addr    = a;
    i_MemRead = 1'b1;
    #1;
    d         = o_ReadData;
    i_MemRead = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    // Still in the window after the last reset edge: all state is zero.
    checks++;
    if (o_ReadData !== 32'h0) begin
      errors++; $display("FAIL reset_rdata_idle got=%h exp=%h", o_ReadData, 32'h0);
    end
    checks++;
    if (o_irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq got=%b exp=0", o_irq);
    end
    checks++;
    if (o_leds !== 8'h00) begin
      errors++; $display("FAIL reset_leds got=%h exp=00", o_leds);
    end
    checks++;
    if (o_an !== 4'b1110) begin
      errors++; $display("FAIL reset_an got=%b exp=1110", o_an);
    end
    checks++;
    if (o_bcd7 !== 8'hC0) begin
      errors++; $display("FAIL reset_bcd7 got=%h exp=c0", o_bcd7);
    end
    for (int k = 0; k < 6; k++) begin
      rd(B + 32'(k * 4), d);
      checks++;
      if (d !== 32'h0) begin
        errors++; $display("FAIL reset_read off=%0h got=%h exp=%h", k * 4, d, 32'h0);
      end
    end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    wr(B + 32'h0, 32'hFFFF_FFF0);
    wr(B + 32'h4, 32'hFFFF_FFFE);
    wr(B + 32'h8, 32'h3);
    rd(B + 32'h4, d);
    checks++;
    if (d !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL timer_tl_start got=%h exp=fffffffe", d);
    end
    step(1);
    rd(B + 32'h4, d);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL timer_tl_max got=%h exp=ffffffff", d);
    end
    checks++;
    if (o_irq !== 1'b0) begin
      errors++; $display("FAIL timer_irq_pre got=%b exp=0", o_irq);
    end
    step(1);
    rd(B + 32'h4, d);
    checks++;
    if (d !== 32'hFFFF_FFF0) begin
      errors++; $display("FAIL timer_reload got=%h exp=fffffff0", d);
    end
    checks++;
    if (o_irq !== 1'b1) begin
      errors++; $display("FAIL timer_irq_set got=%b exp=1", o_irq);
    end
    rd(B + 32'h8, d);
    checks++;
    if (d !== 32'h7) begin
      errors++; $display("FAIL timer_tcon_rd got=%h exp=7", d);
    end
    // Clear the flag; counter keeps running (incremented on the write edge).
    wr(B + 32'h8, 32'h1);
    checks++;
    if (o_irq !== 1'b0) begin
      errors++; $display("FAIL timer_irq_clear got=%b exp=0", o_irq);
    end
    rd(B + 32'h4, d);
    checks++;
    if (d !== 32'hFFFF_FFF1) begin
      errors++; $display("FAIL timer_count_on got=%h exp=fffffff1", d);
    end
    step(2);
    rd(B + 32'h4, d);
    checks++;
    if (d !== 32'hFFFF_FFF3) begin
      errors++; $display("FAIL timer_count_2 got=%h exp=fffffff3", d);
    end
    // TL write wins over the increment.
    wr(B + 32'h4, 32'h5);
    rd(B + 32'h4, d);
    checks++;
    if (d !== 32'h5) begin
      errors++; $display("FAIL timer_tl_write_wins got=%h exp=5", d);
    end
    // Software interrupt; timer stops (TL incremented once on the write edge).
    wr(B + 32'h8, 32'h4);
    checks++;
    if (o_irq !== 1'b1) begin
      errors++; $display("FAIL timer_sw_irq got=%b exp=1", o_irq);
    end
    step(2);
    rd(B + 32'h4, d);
    checks++;
    if (d !== 32'h6) begin
      errors++; $display("FAIL timer_hold got=%h exp=6", d);
    end
    wr(B + 32'h8, 32'h0);
    checks++;
    if (o_irq !== 1'b0) begin
      errors++; $display("FAIL timer_sw_irq_clear got=%b exp=0", o_irq);
    end
  endtask

  task automatic test_overflow_write();
    logic [31:0] d;
    wr(B + 32'h0, 32'h0000_0100);
    wr(B + 32'h4, 32'hFFFF_FFFE);
    wr(B + 32'h8, 32'h3);
    step(1);  // TL = FFFF_FFFF now; next edge is the overflow edge
    wr(B + 32'h8, 32'h1);
    rd(B + 32'h8, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL ovf_tcon got=%h exp=1", d);
    end
    checks++;
    if (o_irq !== 1'b0) begin
      errors++; $display("FAIL ovf_irq got=%b exp=0", o_irq);
    end
    rd(B + 32'h4, d);
    checks++;
    if (d !== 32'h0000_0100) begin
      errors++; $display("FAIL ovf_reload got=%h exp=00000100", d);
    end
    step(1);
    rd(B + 32'h4, d);
    checks++;
    if (d !== 32'h0000_0101) begin
      errors++; $display("FAIL ovf_count got=%h exp=00000101", d);
    end
    wr(B + 32'h8, 32'h0);
  endtask

  task automatic test_scan();
    logic [7:0] seg_exp [4];
    logic [3:0] an_exp  [4];
    int         idx;
    seg_exp = '{8'hC0, 8'hF9, 8'h88, 8'h80};
    an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    // Window after reset edge R; the write commits at R+1.
    wr(B + 32'h10, 32'h0000_8A10);
    for (int c = 1; c <= 17; c++) begin
      idx = (c / 4) % 4;
      checks++;
      if (o_an !== an_exp[idx] || o_bcd7 !== seg_exp[idx]) begin
        errors++;
        $display("FAIL scan c=%0d got an=%b seg=%h exp an=%b seg=%h",
                 c, o_an, o_bcd7, an_exp[idx], seg_exp[idx]);
      end
      if (c < 17) step(1);
    end
    // DIGITS write at R+18 changes segments without moving the scan.
    wr(B + 32'h10, 32'h0000_FFFF);
    checks++;
    if (o_an !== 4'b1110 || o_bcd7 !== 8'h8E) begin
      errors++; $display("FAIL scan_rewrite got an=%b seg=%h exp an=1110 seg=8e", o_an, o_bcd7);
    end
    step(2);
    checks++;
    if (o_an !== 4'b1101 || o_bcd7 !== 8'h8E) begin
      errors++; $display("FAIL scan_continue got an=%b seg=%h exp an=1101 seg=8e", o_an, o_bcd7);
    end
  endtask

  task automatic test_leds_systick();
    logic [31:0] d;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s2;
    wr(B + 32'hC, 32'h1234_56A5);
    checks++;
    if (o_leds !== 8'hA5) begin
      errors++; $display("FAIL leds_out got=%h exp=a5", o_leds);
    end
    rd(B + 32'hC, d);
    checks++;
    if (d !== 32'h0000_00A5) begin
      errors++; $display("FAIL leds_read got=%h exp=000000a5", d);
    end
    wr(B + 32'h10, 32'hDEAD_8A10);
    rd(B + 32'h10, d);
    checks++;
    if (d !== 32'h0000_8A10) begin
      errors++; $display("FAIL digits_read got=%h exp=00008a10", d);
    end
    wr(B + 32'h8, 32'hFFFF_FFF0);
    rd(B + 32'h8, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL tcon_upper got=%h exp=0", d);
    end
    rd(B + 32'h14, s0);
    wr(B + 32'h14, 32'h0);
    rd(B + 32'h14, s1);
    checks++;
    if (s1 !== s0 + 32'd1) begin
      errors++; $display("FAIL systick_write_ignored got=%h exp=%h", s1, s0 + 32'd1);
    end
    step(5);
    rd(B + 32'h14, s2);
    checks++;
    if (s2 - s1 !== 32'd5) begin
      errors++; $display("FAIL systick_delta got=%0d exp=5", s2 - s1);
    end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    wr(B + 32'h4, 32'h55);
    i_addr      = 32'h1000_0004;
    i_WriteData = 32'h1234_5678;
    i_MemWrite  = 1'b1;
    i_MemRead   = 1'b1;
    #1;
    checks++;
    if (o_sel !== 1'b0) begin
      errors++; $display("FAIL decode_sel_out got=%b exp=0", o_sel);
    end
    checks++;
    if (o_ReadData !== 32'h0) begin
      errors++; $display("FAIL decode_rdata_out got=%h exp=0", o_ReadData);
    end
    @(posedge clk);
    #1;
    i_MemWrite = 1'b0;
    i_MemRead  = 1'b0;
    rd(B + 32'h4, d);
    checks++;
    if (d !== 32'h55) begin
      errors++; $display("FAIL decode_tl_kept got=%h exp=55", d);
    end
    checks++;
    if (o_leds !== 8'hA5) begin
      errors++; $display("FAIL decode_leds_kept got=%h exp=a5", o_leds);
    end
    wr(B + 32'h1C, 32'hFFFF_FFFF);
    rd(B + 32'h1C, d);
    checks++;
    if (d !== 32'h0 || o_sel !== 1'b1) begin
      errors++; $display("FAIL decode_rsvd7 got=%h sel=%b exp=0 sel=1", d, o_sel);
    end
    rd(B + 32'h18, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL decode_rsvd6 got=%h exp=0", d);
    end
    rd(B + 32'hF, d);
    checks++;
    if (d !== 32'h0000_00A5) begin
      errors++; $display("FAIL decode_byte_ofs got=%h exp=000000a5", d);
    end
    i_addr = B + 32'hC;
    #1;
    checks++;
    if (o_ReadData !== 32'h0) begin
      errors++; $display("FAIL decode_no_read got=%h exp=0", o_ReadData);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  vals [3];
    vals = '{8'h11, 8'h22, 8'h33};
    for (int k = 0; k < 3; k++) begin
      wr(B + 32'hC, {24'd0, vals[k]});
      checks++;
      if (o_leds !== vals[k]) begin
        errors++; $display("FAIL b2b_leds k=%0d got=%h exp=%h", k, o_leds, vals[k]);
      end
    end
    wr(B + 32'h0, 32'hCAFE_F00D);
    rd(B + 32'h0, d);
    checks++;
    if (d !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL b2b_th got=%h exp=cafef00d", d);
    end
    // Reset mid-count has priority over a concurrent store and the increment.
    wr(B + 32'h4, 32'h10);
    wr(B + 32'h8, 32'h1);
    reset       = 1'b1;
    i_addr      = B + 32'hC;
    i_WriteData = 32'hFF;
    i_MemWrite  = 1'b1;
    step(1);
    i_MemWrite  = 1'b0;
    checks++;
    if (o_leds !== 8'h00) begin
      errors++; $display("FAIL rst_mid_leds got=%h exp=00", o_leds);
    end
    rd(B + 32'h4, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL rst_mid_tl got=%h exp=0", d);
    end
    rd(B + 32'h14, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL rst_mid_systick got=%h exp=0", d);
    end
    rd(B + 32'h8, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL rst_mid_tcon got=%h exp=0", d);
    end
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  initial begin
    reset       = 1'b1;
    i_addr      = 32'h0;
    i_WriteData = 32'h0;
    i_MemRead   = 1'b0;
    i_MemWrite  = 1'b0;
    test_reset();
    test_timer();
    test_overflow_write();
    test_scan();
    test_leds_systick();
    test_decode();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mmio_peripheral.md
# mmio_peripheral

Memory-mapped peripheral block that sits beside the data memory on the pipeline processor's MEM stage. It decodes the EX/MEM address and performs load/store accesses to a programmable timer with interrupt flag, a free-running cycle counter, an 8-bit LED register and a 16-bit display register. It also time-multiplexes the display register onto a 4-digit common-anode 7-segment display. The data memory muxes `o_ReadData` into its own read path whenever `o_sel` is high.

## Interface

Parameters:
- `BASE_ADDR`, default 32'h4000_0000. Byte base address of the 32-byte peripheral window.
- `SCAN_DIV`, default 100000. Number of clk cycles each display digit is driven; must be ≥ 2.

Ports:
- `clk`  in  1  system clock. Single clock domain; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_addr`  in  32  byte address from the EX/MEM register (ALU result).
- `i_WriteData`  in  32  store data.
- `i_MemRead`  in  1  load strobe.
- `i_MemWrite`  in  1  store strobe.
- `o_sel`  out  1  combinational; high when `i_addr[31:5] == BASE_ADDR[31:5]`.
- `o_ReadData`  out  32  combinational load data.
- `o_irq`  out  1  timer interrupt request; equals TCON[2].
- `o_leds`  out  8  LED register.
- `o_an`  out  4  digit anodes, active-low one-hot.
- `o_bcd7`  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation

Register map (offset = `i_addr[4:2]`; `i_addr[1:0]` is ignored):
- 0x00 TH: timer reload value, R/W.
- 0x04 TL: timer count, R/W.
- 0x08 TCON: bits [2:0] are R/W; upper bits read 0.
  - bit 0: enable.
  - bit 1: interrupt enable.
  - bit 2: interrupt status.
- 0x0C LEDS: R/W. Only bits [7:0] are stored; upper bits read 0.
- 0x10 DIGITS: R/W. Only bits [15:0] are stored.
  - Digit 0 (rightmost) displays [3:0].
  - Digit 3 displays [15:12].
- 0x14 SYSTICK: read-only cycle counter; writes are ignored.
- 0x18 and 0x1C: reads return 0; writes are ignored.

Reads:
- `o_ReadData` is the addressed register when `i_MemRead && o_sel`; otherwise it is 32'h0.

Writes:
- A write commits at the clock edge when `i_MemWrite && o_sel`.
- No write occurs when `o_sel` is low.

Timer (evaluated every cycle while TCON[0] = 1):
- If TL == 32'hFFFF_FFFF: TL <= TH, and if TCON[1] = 1 then TCON[2] <= 1.
- Otherwise: TL <= TL + 1. The increment is modulo 2^32.
- While TCON[0] = 0, TL holds its value.

Simultaneous events:
- A software write to TL in the same cycle as an increment or reload: the write wins.
- A software write to TCON in the same cycle as a status set: the written value wins, so software can clear the flag at the exact overflow cycle.
- Writing TCON[2] = 1 sets the flag, which is permitted as a software interrupt.

SYSTICK:
- Increments by 1 every cycle, wrapping at 2^32.
- It is unaffected by timer enable.

Display scan:
- A scan counter counts 0 … SCAN_DIV−1, then wraps to 0.
- On each wrap, the 2-bit digit index advances 0→1→2→3→0.
- `o_an` = ~(4'b0001 << index).
- `o_bcd7` is the hex decode of the selected nibble with dp = 1 (off). Required decode values:
  - 0 → 8'hC0
  - 1 → 8'hF9
  - 8 → 8'h80
  - A → 8'h88
  - F → 8'h8E
- `o_an` and `o_bcd7` are combinational from the index and DIGITS registers.

## Timing

- Reset: every register clears to 0, including TH, TL, TCON, LEDS, DIGITS, SYSTICK, the scan counter and the digit index. Resulting outputs:
  - `o_irq` = 0, `o_leds` = 8'h00.
  - `o_an` = 4'b1110, `o_bcd7` = 8'hC0.
  - `o_ReadData` = 0 unless a read is presented.
- Reset asserted mid-count: all state clears at that edge; reset has priority over writes and increments.
- Read latency is 0 cycles: data is valid in the same cycle as the address, as the MEM stage requires for the forward path to ID.
- Write latency: the new value is visible to a read in the cycle after the store.
- Overflow timing: if TL = 32'hFFFF_FFFF at edge N with TCON = 3'b011, then after edge N TL = TH and `o_irq` = 1.
- Each digit is driven for exactly SCAN_DIV cycles. A DIGITS write changes the segments in the next cycle without resetting the scan.

## Test plan

- Reset, then read all six offsets → every read returns 0; `o_an` = 1110, `o_bcd7` = 8'hC0, `o_irq` = 0.
- Write TH = 32'hFFFF_FFF0, TL = 32'hFFFF_FFFE, TCON = 3 → TL reads FFFF_FFFF one cycle later. The next cycle gives TL = FFFF_FFF0 and `o_irq` = 1. Writing TCON = 1 clears `o_irq` while counting continues.
- Store TCON = 3'b001 in the exact overflow cycle → TCON[2] stays 0; TL reloads from TH.
- SCAN_DIV = 4, DIGITS = 16'h8A10 → the anode sequence 1110/1101/1011/0111 repeats every 16 cycles. Segments follow 8'hC0, F9, 88, 80 in step.
- Write LEDS = 32'h1234_56A5 → `o_leds` = 8'hA5 and LEDS reads 32'h0000_00A5. Writing SYSTICK leaves it counting, and two reads k cycles apart differ by k.
- Address 0x1000_0004 with `i_MemWrite` → `o_sel` = 0 and all registers are unchanged. Offset 0x1C read → returns 0 with `o_sel` = 1.
